// File: rtl/uart_line_arbiter_if.sv
// uart_line_arbiter_if
//   Bundles the requester side (request levels, packed lines, grant/ack) and
//   the feed side (go, line bus, tx_valid snoop) of the line arbiter.
//   slave  : the arbiter's view (drives grant/ack/go/line/busy).
//   master : the view of whoever drives requests and the feed snoop.
//   Ports:
//     i_req            level request per requester
//     i_lines          packed lines, requester k in slice k, first byte in slice MSB
//     o_grant          one-hot grant, held from capture until ack
//     o_ack            one-cycle completion pulse to the granted requester
//     o_tx_go          feed go
//     o_dat_ascii_line registered line presented to the feed
//     i_feed_valid     feed tx_valid tap, one pulse per byte enqueued
//     o_busy           arbiter not idle
interface uart_line_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int LINE_BYTES = 34
);
  logic [NUM_REQ-1:0]              i_req;
  logic [NUM_REQ*LINE_BYTES*8-1:0] i_lines;
  logic [NUM_REQ-1:0]              o_grant;
  logic [NUM_REQ-1:0]              o_ack;
  logic                            o_tx_go;
  logic [LINE_BYTES*8-1:0]         o_dat_ascii_line;
  logic                            i_feed_valid;
  logic                            o_busy;

  modport slave (
    input  i_req, i_lines, i_feed_valid,
    output o_grant, o_ack, o_tx_go, o_dat_ascii_line, o_busy
  );

  modport master (
    output i_req, i_lines, i_feed_valid,
    input  o_grant, o_ack, o_tx_go, o_dat_ascii_line, o_busy
  );
endinterface

// File: rtl/uart_line_arbiter.sv
// uart_line_arbiter
//   Shares one uart_tx_feed between NUM_REQ line producers. Round-robin at
//   whole-line granularity: a granted line is presented to the feed with go
//   held high until LINE_BYTES feed valids are seen, then go drops, the
//   requester gets an ack pulse, and GAP_CYCLES idle cycles pass before the
//   next grant so the feed sees go low and returns to its idle state.
//   Ports:
//     i_clk_20mhz  system clock
//     i_rst_20mhz  synchronous active-high reset
//     bus          uart_line_arbiter_if.slave (requests, lines, grant, ack,
//                  go, line bus, feed valid snoop, busy)
module uart_line_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int LINE_BYTES = 34,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 i_clk_20mhz,
  input  logic                 i_rst_20mhz,
  uart_line_arbiter_if.slave   bus
);

  localparam int LW = LINE_BYTES * 8;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_e;

  // Blank line: spaces followed by CR LF, shown while nothing is granted.
  function automatic logic [LW-1:0] blank_line();
    logic [LW-1:0] l;
    for (int b = 0; b < LINE_BYTES; b++) l[b*8 +: 8] = 8'h20;
    l[15:0] = 16'h0D0A;
    return l;
  endfunction

  localparam logic [LW-1:0] BLANK_LINE = blank_line();

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               go_q, go_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [LW-1:0]      line_q, line_d;

  // Round-robin winner: first set request after the last winner.
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [LW-1:0]      win_line;

  always_comb begin
    int k;
    win_found = 1'b0;
    win_idx   = ptr_q;
    k         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && bus.i_req[k]) begin
        win_found = 1'b1;
        win_idx   = PW'(k);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_oh
    assign win_oh[g] = (win_idx == PW'(g));
  end

  assign win_line = bus.i_lines[int'(win_idx)*LW +: LW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    go_d    = go_q;
    grant_d = grant_q;
    ack_d   = '0;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          line_d  = win_line;
          grant_d = win_oh;
          ptr_d   = win_idx;
          cnt_d   = '0;
          go_d    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Line and grant stay frozen: the feed re-captures the line every
        // cycle while it waits for tx_ready.
        if (bus.i_feed_valid) begin
          if (cnt_q == 6'(LINE_BYTES - 1)) begin
            go_d    = 1'b0;
            ack_d   = grant_q;
            grant_d = '0;
            gap_d   = '0;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      RELEASE: begin
        // Requests are ignored here so go stays low long enough for the feed
        // to leave its wait state before the next line.
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      line_q  <= BLANK_LINE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      line_q  <= line_d;
    end
  end

  assign bus.o_tx_go          = go_q;
  assign bus.o_busy           = busy_q;
  assign bus.o_grant          = grant_q;
  assign bus.o_ack            = ack_q;
  assign bus.o_dat_ascii_line = line_q;

endmodule

// File: tb/tb_uart_line_arbiter.sv
module tb_uart_line_arbiter;
  localparam int N = 2, LB = 34, GAP = 4, W = LB * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #25 clk = ~clk;

  uart_line_arbiter_if #(.NUM_REQ(N), .LINE_BYTES(LB)) bus();

  uart_line_arbiter #(.NUM_REQ(N), .LINE_BYTES(LB), .GAP_CYCLES(GAP)) dut (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst),
    .bus         (bus)
  );

  int total = 0, bad = 0;

  // Transaction-level model: who is being served, how many valids so far,
  // how long go has been low, last winner.
  int in_line = 0, nval = 0, lowcnt = 1000, last = N - 1, cur = 0;
  logic [W-1:0] exp_line, blank, rx, cap;
  int glog[$];
  int acks = 0;

  // Feed model: 0 idle, 1 capture (waits tx_ready), 2 send, 3 wait go low.
  int fs = 0, bi = 0;
  bit tx_ready = 1'b1;
  bit inject = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++) if (r[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  task automatic cyc();
    logic [N-1:0]   r, oh;
    logic [N*W-1:0] l;
    logic           fe, re;
    r = bus.i_req; l = bus.i_lines; fe = bus.i_feed_valid; re = rst;
    @(posedge clk); #1;
    if (re) begin
      chk("rst_go",    W'(bus.o_tx_go), '0);
      chk("rst_grant", W'(bus.o_grant), '0);
      chk("rst_ack",   W'(bus.o_ack),   '0);
      chk("rst_busy",  W'(bus.o_busy),  '0);
      chk("rst_line",  bus.o_dat_ascii_line, blank);
      in_line = 0; lowcnt = 1000; last = N - 1; fs = 0; bi = 0;
      bus.i_feed_valid = 1'b0;
      return;
    end
    if (in_line != 0) begin
      oh = N'(1) << cur;
      if (fe) nval++;
      if (nval == LB) begin
        chk("ack_pulse",  W'(bus.o_ack),   W'(oh));
        chk("ack_go_low", W'(bus.o_tx_go), '0);
        chk("ack_grant",  W'(bus.o_grant), '0);
        chk("ack_busy",   W'(bus.o_busy),  W'(1));
        chk("feed_bytes", rx, exp_line);
        in_line = 0; lowcnt = 1;
      end else begin
        chk("send_ack",   W'(bus.o_ack),   '0);
        chk("send_go",    W'(bus.o_tx_go), W'(1));
        chk("send_grant", W'(bus.o_grant), W'(oh));
        chk("send_line",  bus.o_dat_ascii_line, exp_line);
        chk("send_busy",  W'(bus.o_busy),  W'(1));
      end
    end else if (lowcnt >= GAP + 1 && r != '0) begin
      cur = rr(r, last); last = cur; oh = N'(1) << cur;
      exp_line = l[cur*W +: W]; in_line = 1; nval = 0;
      chk("grant_go",   W'(bus.o_tx_go), W'(1));
      chk("grant_oh",   W'(bus.o_grant), W'(oh));
      chk("grant_line", bus.o_dat_ascii_line, exp_line);
      chk("grant_ack",  W'(bus.o_ack),   '0);
      chk("feed_idle_at_go", W'(fs), '0);
      glog.push_back(cur);
    end else begin
      if (lowcnt < 1000) lowcnt++;
      chk("idle_go",    W'(bus.o_tx_go), '0);
      chk("idle_grant", W'(bus.o_grant), '0);
      chk("idle_ack",   W'(bus.o_ack),   '0);
      chk("idle_busy",  W'(bus.o_busy),  W'(lowcnt <= GAP));
    end
    if (bus.o_ack != '0) acks++;
    bus.i_feed_valid = 1'b0;
    case (fs)
      0: if (bus.o_tx_go) fs = 1;
         else if (inject && $urandom_range(3) == 0) bus.i_feed_valid = 1'b1;
      1: if (tx_ready) begin cap = bus.o_dat_ascii_line; fs = 2; bi = 0; rx = '0; end
      2: begin
           bus.i_feed_valid = 1'b1;
           rx = {rx[W-9:0], cap[W-1-8*bi -: 8]};
           bi++;
           if (bi == LB) fs = 3;
         end
      default: if (!bus.o_tx_go) fs = 0;
    endcase
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int a0, c;
    a0 = acks; c = 0;
    while (acks - a0 < n && c < budget) begin cyc(); c++; end
    chk(tag, W'(acks - a0), W'(n));
  endtask

  task automatic wait_byte(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (!(in_line != 0 && nval >= n) && c < budget) begin cyc(); c++; end
    chk(tag, W'(in_line != 0 && nval >= n), W'(1));
  endtask

  task automatic rand_line(input int k);
    for (int i = 0; i < LB; i++) bus.i_lines[k*W + 8*i +: 8] = 8'($urandom);
  endtask

  task automatic set_text(input int k, input string s);
    for (int i = 0; i < LB - 2; i++)
      bus.i_lines[k*W + W-1-8*i -: 8] = (i < s.len()) ? 8'(s[i]) : 8'h20;
    bus.i_lines[k*W + 15 -: 16] = 16'h0D0A;
  endtask

  initial begin
    for (int b = 0; b < LB; b++) blank[b*8 +: 8] = 8'h20;
    blank[15:0] = 16'h0D0A;
    bus.i_req = '0; bus.i_feed_valid = 1'b0; bus.i_lines = '0;
    set_text(0, "ACL X=+0.00 Y=+0.00 Z=+1.00");
    rand_line(1);

    // reset, then single request from requester 0
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    bus.i_req = 2'b01;
    wait_acks(1, 100, "single_ack");
    bus.i_req = '0;
    repeat (8) cyc();

    // both requesting: 0,1,0,1 from reset
    rst = 1'b1; cyc(); rst = 1'b0;
    glog.delete();
    bus.i_req = 2'b11;
    wait_acks(4, 400, "rr_acks");
    bus.i_req = '0;
    chk("rr_count", W'(glog.size()), W'(4));
    if (glog.size() >= 4) begin
      chk("rr_order0", W'(glog[0]), W'(0));
      chk("rr_order1", W'(glog[1]), W'(1));
      chk("rr_order2", W'(glog[2]), W'(0));
      chk("rr_order3", W'(glog[3]), W'(1));
    end
    repeat (8) cyc();

    // feed stalled in capture for 100 cycles; line source changes meanwhile
    tx_ready = 1'b0;
    bus.i_req = 2'b01;
    repeat (50) cyc();
    rand_line(0);
    repeat (50) cyc();
    tx_ready = 1'b1;
    wait_acks(1, 100, "stall_ack");
    bus.i_req = '0;
    repeat (8) cyc();

    // requester 1 drops its request mid-line, requester 0 then waiting
    glog.delete();
    rand_line(1);
    bus.i_req = 2'b10;
    wait_byte(17, 100, "drop_reach");
    bus.i_req = 2'b01;
    wait_acks(2, 200, "drop_acks");
    bus.i_req = '0;
    if (glog.size() >= 2) begin
      chk("drop_first",  W'(glog[0]), W'(1));
      chk("drop_second", W'(glog[1]), W'(0));
    end
    repeat (8) cyc();

    // reset at byte 17, then requester 0 wins first
    bus.i_req = 2'b11;
    wait_byte(17, 200, "mid_reach");
    rst = 1'b1; cyc(); rst = 1'b0;
    glog.delete();
    cyc();
    chk("post_rst_grant_cnt", W'(glog.size()), W'(1));
    if (glog.size() >= 1) chk("post_rst_winner", W'(glog[0]), W'(0));
    wait_acks(1, 100, "post_rst_ack");
    bus.i_req = '0;

    // randomized traffic with stray feed valids between lines
    inject = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) bus.i_req = N'($urandom);
      if ($urandom_range(15) == 0) rand_line($urandom_range(N - 1));
      tx_ready = ($urandom_range(3) != 0);
      cyc();
    end
    inject = 1'b0;
    tx_ready = 1'b1;
    bus.i_req = '0;
    repeat (60) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
